// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite bitmap path: loader FSM states, bitmap
// store address/pixel widths, the default frame sync byte and the sprite
// geometry used by both the loader and the bitmap store.
package sprite_pkg;

    // Bitmap store geometry: 8 sprites of 16x16 pixels, 4 bits per pixel.
    localparam int ADDR_W       = 11;
    localparam int PIXEL_W      = 4;
    localparam int SPR_NSPRITES = 8;
    localparam int SPR_WIDTH    = 16;
    localparam int SPR_HEIGHT   = 16;
    localparam int SPR_PIX      = SPR_WIDTH * SPR_HEIGHT;
    localparam int SPR_DEPTH    = SPR_NSPRITES * SPR_PIX;

    // Byte that opens every frame on the loader input stream.
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Loader states. S_CHK is only reachable when the checksum is built.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INDEX = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_CHK   = 3'd4
    } loader_state_e;

    // Address of one pixel of data byte k: the high nibble lands on the even
    // address (odd=0), the low nibble on the following odd address (odd=1).
    // The sum wraps naturally at the store size.
    function automatic logic [ADDR_W-1:0] pixel_addr(
        input logic [ADDR_W-1:0] base,
        input logic [31:0]       k,
        input logic              odd
    );
        logic [31:0] offs;
        offs = (k << 1) | {31'd0, odd};
        return base + offs[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sprite_loader.sv
// sprite_loader: turns a framed byte stream (SYNC, sprite index, packed
// 4bpp pixel bytes) into one pixel write per cycle into the bitmap store.
// Optional feature macro: SPRITE_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte per frame and drives chk_err on mismatch.
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int         NSPRITES = SPR_NSPRITES,
    parameter int         WIDTH    = SPR_WIDTH,
    parameter int         HEIGHT   = SPR_HEIGHT,
    parameter logic [7:0] SYNC     = SYNC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_add,
    output logic [PIXEL_W-1:0] wr_pixel,
    output logic               busy,
    output logic               done,
    output logic               chk_err
);

    localparam int PIX    = WIDTH * HEIGHT;
    localparam int NB     = PIX / 2;
    localparam int KW     = $clog2(NB);
    localparam int IDX_W  = $clog2(NSPRITES);
    localparam int PIX_SH = $clog2(PIX);

    loader_state_e      state_q;
    logic [ADDR_W-1:0]  base_q;
    logic [KW-1:0]      k_q;
    logic [PIXEL_W-1:0] lo_q;

    logic               in_ready_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_add_q;
    logic [PIXEL_W-1:0] wr_pixel_q;
    logic               busy_q;
    logic               done_q;

`ifdef SPRITE_LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
    logic               chk_err_q;
`endif

    logic               accept_d;
    logic               last_byte_d;
    logic [ADDR_W-1:0]  index_base_d;

    // Handshake, last-byte detect and the base address an index byte selects.
    always_comb begin
        accept_d     = in_valid && in_ready_q;
        last_byte_d  = (k_q == KW'(NB - 1));
        index_base_d = ADDR_W'(in_data[IDX_W-1:0]) << PIX_SH;
    end

    // Frame FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            k_q        <= '0;
            lo_q       <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_add_q   <= '0;
            wr_pixel_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            // Strobes default low; address/pixel hold their last value.
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
            chk_err_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    // busy drops here, one cycle after the done pulse.
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (accept_d && (in_data == SYNC)) begin
                        busy_q  <= 1'b1;
                        state_q <= S_INDEX;
                    end
                end

                S_INDEX: begin
                    in_ready_q <= 1'b1;
                    if (accept_d) begin
                        base_q  <= index_base_d;
                        k_q     <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        csum_q  <= 8'h00;
`endif
                        state_q <= S_HI;
                    end
                end

                S_HI: begin
                    // Write the high nibble straight away and stall the
                    // input for one cycle while the low nibble goes out.
                    if (accept_d) begin
                        lo_q       <= in_data[3:0];
                        wr_en_q    <= 1'b1;
                        wr_add_q   <= pixel_addr(base_q, 32'(k_q), 1'b0);
                        wr_pixel_q <= in_data[7:4];
                        in_ready_q <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ in_data;
`endif
                        state_q    <= S_LO;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end

                S_LO: begin
                    wr_en_q    <= 1'b1;
                    wr_add_q   <= pixel_addr(base_q, 32'(k_q), 1'b1);
                    wr_pixel_q <= lo_q;
                    in_ready_q <= 1'b1;
                    if (last_byte_d) begin
`ifdef SPRITE_LOADER_CHECKSUM_EN
                        state_q <= S_CHK;
`else
                        // Frame ends with the final pixel write.
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
`endif
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= S_HI;
                    end
                end

`ifdef SPRITE_LOADER_CHECKSUM_EN
                S_CHK: begin
                    // Pixels are already written; a bad checksum only flags.
                    in_ready_q <= 1'b1;
                    if (accept_d) begin
                        done_q    <= 1'b1;
                        chk_err_q <= (in_data != csum_q);
                        state_q   <= S_IDLE;
                    end
                end
`endif

                default: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_add   = wr_add_q;
    assign wr_pixel = wr_pixel_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef SPRITE_LOADER_CHECKSUM_EN
    assign chk_err  = chk_err_q;
`else
    assign chk_err  = 1'b0;
`endif

endmodule

// File: doc/sprite_loader.md
# sprite_loader

Streaming writer for the sprite bitmap RAM: it accepts a byte stream (typically from the UART receiver) and writes 16x16, 4-bit-per-pixel sprites into the 8-sprite, 2048-entry bitmap store. The display path reads that store. Each frame carries a sync byte, a sprite index and packed pixel data, with two pixels per byte. The loader unpacks the data into one pixel write per cycle.

## Interface
- NSPRITES, 8: sprites in the store; power of 2.
- WIDTH, 16: sprite width in pixels; power of 2.
- HEIGHT, 16: sprite height in pixels; power of 2.
- SYNC, 8'hA5: frame start byte.
- clk  in  1  system clock; everything sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte; a transfer happens when in_valid and in_ready are both high.
- wr_en  out  1  pixel write strobe to the bitmap RAM.
- wr_add  out  11  write address = sprite*WIDTH*HEIGHT + pixel index.
- wr_pixel  out  4  pixel value.
- busy  out  1  high from sync acceptance until the frame ends.
- done  out  1  one-cycle pulse when a frame completes.
- chk_err  out  1  one-cycle pulse, coincident with done, on checksum mismatch.

## Operation
- Frame length: PIX = WIDTH*HEIGHT = 256 pixels, NB = PIX/2 = 128 data bytes.
- FSM states:
  - S_IDLE: in_ready=1. Accepted byte == SYNC → S_INDEX. Any other byte is discarded and the state stays S_IDLE.
  - S_INDEX: in_ready=1. Accepted byte sets base = in_data[log2(NSPRITES)-1:0] * PIX; upper bits are ignored. Byte counter k=0 → S_HI.
  - S_HI: in_ready=1. On an accepted byte B: latch B and → S_LO.
  - S_LO: in_ready=0. Write B[3:0] (see Timing). If k==NB-1 → S_CHK (macro defined) or S_IDLE; else k++ → S_HI.
  - S_CHK: in_ready=1. Accepted byte is compared with the running checksum → S_IDLE.
- Pixel order: the high nibble goes to the lower address. Byte k writes base+2k (B[7:4]) and base+2k+1 (B[3:0]).
- Sync value inside data is ordinary data. There is no escaping and no resync mid-frame.
- wr_add wraps modulo 2048; it is never out of range because base+2k+1 ≤ base+PIX-1.
- in_valid low in any state: wait with no state change.
- Reset mid-frame: → S_IDLE. All outputs return to reset values. The partially written sprite is left as-is.
- Reset values: in_ready=0 during the reset cycle and 1 after it; wr_en=0, wr_add=0, wr_pixel=0, busy=0, done=0, chk_err=0.

## Timing
- All outputs are registered.
- Byte accepted at cycle t in S_HI:
  - t+1: wr_en=1, wr_add=base+2k, wr_pixel=B[7:4], in_ready=0.
  - t+2: wr_en=1, wr_add=base+2k+1, wr_pixel=B[3:0], in_ready=1.
  - The next byte can therefore be accepted at t+2.
- Peak throughput: one byte per 2 cycles, with continuous wr_en under back-to-back input.
- Last data byte, macro undefined: done=1 at t+2 (same cycle as the final write); busy falls at t+3.
- Checksum byte, macro defined: accepted at cycle c → done=1 at c+1, plus chk_err if mismatched; busy falls at c+2.
- busy rises the cycle after SYNC is accepted.

## Configuration
- SPRITE_LOADER_CHECKSUM_EN defined:
  - The running XOR of the NB data bytes is kept; its start value is 8'h00.
  - One checksum byte follows the data (state S_CHK).
  - chk_err pulses with done on mismatch. Writes are not rolled back.
- SPRITE_LOADER_CHECKSUM_EN undefined:
  - S_CHK and the XOR register are not built.
  - The frame ends after the last data byte; chk_err is tied to 0.

## Structure
- Shared package sprite_pkg holds:
  - the FSM state enum (S_IDLE, S_INDEX, S_HI, S_LO, S_CHK);
  - the bitmap address width (11), pixel width (4) and default SYNC value;
  - the sprite geometry constants used by this block and the bitmap store.
- Single module, no sub-module; the write-capable bitmap RAM is a separate block.

## Test plan
- Reset, then SYNC, index 3, 128 bytes 8'h12 back-to-back → 256 writes at addresses 768..1023, alternating 1/2, wr_en continuous, done at the final write, in_ready toggling 1/0.
- Garbage 8'h00, 8'hFF before SYNC → no writes, busy stays 0; the following frame to index 0 writes 0..255.
- Index byte 8'hFD (NSPRITES=8) → base 1280. in_valid gaps of random 0-5 cycles → same address and data sequence, no extra writes.
- rst asserted at data byte 40 → wr_en=0 and busy=0 the next cycle. A fresh frame afterwards writes its full 256 pixels.
- Macro defined: bytes 8'h01..8'h80 with checksum 8'h80 → done=1, chk_err=0. With checksum 8'h00 → done=1 and chk_err=1 in the same cycle.
- Data byte equal to 8'hA5 mid-frame → written as pixels 10 and 5; frame length unchanged.
